sata_crc_checker: RTL and testbench

- Receive-side counterpart of the Link-layer CRC generator. Sits after the descrambler in the Link RX path.
- Takes a descrambled frame stream whose last dword is the CRC and checks that CRC against the payload.
- Forwards only the payload dwords, with the CRC dword stripped. The error flag is attached to the last payload dword, and a one-cycle per-frame status pulse is produced.

---
 rtl/sata_crc_pkg.sv | 28 ++
 rtl/sata_crc_checker.sv | 89 ++++++++
 tb/tb_sata_crc_checker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sata_crc_pkg.sv
// Shared CRC definitions for the SATA Link layer.
// Both the TX-side CRC generator and the RX-side checker use this package,
// so the two ends agree on the seed and the update function.
package sata_crc_pkg;

  localparam logic [31:0] SATA_CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } hold_state_t;

  // CRC-32 update over one dword: MSB-first, no reflection, no final XOR.
  function automatic logic [31:0] sata_crc32_step(input logic [31:0] crc,
                                                  input logic [31:0] dat);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ dat[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ SATA_CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_crc_checker.sv
// SATA Link RX CRC checker.
// Accepts a descrambled frame whose eop dword is the received CRC, forwards
// only the payload dwords, and flags a CRC mismatch on the last payload dword.
// Each dword is held until its successor arrives, because only then is it
// known not to be the CRC. A registered one-cycle status pulse follows every
// eop transfer; an eop with nothing held is a runt frame and always errors.
module sata_crc_checker
  import sata_crc_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = SATA_CRC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_dat,
  input  logic        i_val,
  input  logic        i_eop,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  output logic        o_err,
  input  logic        o_rdy,
  output logic        stat_val,
  output logic        stat_err
);

  hold_state_t state;
  hold_state_t state_next;
  logic [31:0] hold_dat;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic        hold_full;
  logic        in_xfer;

  assign hold_full = (state == ST_HELD);
  assign crc_next  = sata_crc32_step(crc, hold_dat);
  assign in_xfer   = i_val & i_rdy;

  // Handshake and payload outputs; the held dword goes out alongside its successor.
  always_comb begin
    i_rdy = ~hold_full | o_rdy;
    o_val = hold_full & i_val;
    o_dat = hold_dat;
    o_eop = i_eop;
    o_err = i_eop & (crc_next != i_dat);
  end

  // Hold-register occupancy: fill on a non-eop dword, drain on the eop dword.
  always_comb begin
    state_next = state;
    if (in_xfer) begin
      if (i_eop) state_next = ST_EMPTY;
      else       state_next = ST_HELD;
    end
  end

  // State register; reset drops any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  // Hold data and running CRC; the CRC reseeds at every frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_dat <= '0;
      crc      <= CRC_INIT;
    end else if (in_xfer) begin
      if (i_eop) begin
        crc <= CRC_INIT;
      end else begin
        if (hold_full) crc <= crc_next;
        hold_dat <= i_dat;
      end
    end
  end

  // Per-frame status pulse, one cycle after the eop transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_val <= 1'b0;
      stat_err <= 1'b0;
    end else begin
      stat_val <= in_xfer & i_eop;
      stat_err <= hold_full ? o_err : 1'b1;
    end
  end

endmodule

// File: tb/tb_sata_crc_checker.sv
// Testbench for sata_crc_checker.
// A table of frames is driven through the checker; expected payload dwords
// and frame statuses are queued when driven and popped as the DUT emits them.
// Mid-frame reset is exercised by a hand-written sequence.
module tb_sata_crc_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'h52325032;

  typedef struct {
    logic [31:0] dat;
    logic        eop;
    logic        err;
  } out_t;

  typedef struct {
    int          len;
    logic [31:0] base;
    logic        corrupt;
    logic        gap;
    logic        bp;
    logic        idle_after;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_dat = '0;
  logic        i_val = 1'b0;
  logic        i_eop = 1'b0;
  logic        i_rdy;
  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_err;
  logic        o_rdy = 1'b1;
  logic        stat_val;
  logic        stat_err;

  int   tests_run = 0;
  int   tests_failed = 0;
  out_t out_q[$];
  logic stat_q[$];
  logic tb_held = 1'b0;
  logic stat_pend = 1'b0;
  logic bp_mode = 1'b0;
  int   bp_cnt = 0;
  frame_t frames[7];

  sata_crc_checker dut (
    .clk      (clk),
    .reset    (reset),
    .i_dat    (i_dat),
    .i_val    (i_val),
    .i_eop    (i_eop),
    .i_rdy    (i_rdy),
    .o_dat    (o_dat),
    .o_val    (o_val),
    .o_eop    (o_eop),
    .o_err    (o_err),
    .o_rdy    (o_rdy),
    .stat_val (stat_val),
    .stat_err (stat_err)
  );

  always #5 clk = ~clk;

  // Reference CRC: fold the dword in first, then shift 32 times.
  function automatic logic [31:0] model_crc(input logic [31:0] crc, input logic [31:0] dat);
    logic [31:0] c;
    c = crc ^ dat;
    repeat (32) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Output-ready pattern: always ready, or 1,0,0 repeating under backpressure.
  always @(negedge clk) begin
    bp_cnt++;
    o_rdy = bp_mode ? (bp_cnt % 3 == 0) : 1'b1;
  end

  // Monitor: checks handshake, payload and status against the bench's own model.
  always @(negedge clk) begin
    logic exp_rdy;
    logic xfer;
    out_t e;
    #1;
    if (reset) begin
      tb_held   = 1'b0;
      stat_pend = 1'b0;
    end else begin
      exp_rdy = !tb_held || o_rdy;
      if (i_val) check_output("i_rdy", {31'b0, i_rdy}, {31'b0, exp_rdy});
      if (o_val || (tb_held && i_val)) check_output("o_val", {31'b0, o_val}, {31'b0, tb_held && i_val});
      if (o_val && o_rdy) begin
        if (out_q.size() == 0) begin
          check_output("unexpected_out", o_dat, 32'hxxxxxxxx);
        end else begin
          e = out_q.pop_front();
          check_output("o_dat", o_dat, e.dat);
          check_output("o_eop", {31'b0, o_eop}, {31'b0, e.eop});
          if (e.eop) check_output("o_err", {31'b0, o_err}, {31'b0, e.err});
        end
      end
      if (stat_val || stat_pend) begin
        check_output("stat_val", {31'b0, stat_val}, {31'b0, stat_pend});
        if (stat_pend) begin
          if (stat_q.size() == 0) check_output("stat_q_empty", 32'd0, 32'd1);
          else check_output("stat_err", {31'b0, stat_err}, {31'b0, stat_q.pop_front()});
        end
      end
      xfer      = i_val && exp_rdy;
      stat_pend = xfer && i_eop;
      if (xfer) tb_held = !i_eop;
    end
  end

  // Present one dword and wait (bounded) until it is accepted.
  task automatic send_word(input logic [31:0] dat, input logic eop, input logic gap);
    logic acc;
    int   n;
    if (gap) begin
      @(negedge clk);
      i_val = 1'b0;
      @(posedge clk);
    end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      i_val = 1'b1;
      i_dat = dat;
      i_eop = eop;
      #1;
      acc = i_rdy;
      @(posedge clk);
      n++;
    end
    if (!acc) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    i_val = 1'b0;
    i_eop = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  // Drive one frame and queue its expected payload and status.
  task automatic apply_stimulus(input frame_t f);
    logic [31:0] crc;
    logic [31:0] w;
    bp_mode = f.bp;
    if (f.len == 0) begin
      stat_q.push_back(1'b1);
      send_word(f.base, 1'b1, f.gap);
    end else begin
      crc = INIT;
      for (int i = 0; i < f.len; i++) begin
        w = f.base + i;
        crc = model_crc(crc, w);
        out_q.push_back('{w, (i == f.len - 1), f.corrupt});
        send_word(w, 1'b0, f.gap && (i % 2 == 1));
      end
      stat_q.push_back(f.corrupt);
      send_word(crc ^ {31'b0, f.corrupt}, 1'b1, f.gap);
    end
    bp_mode = 1'b0;
    if (f.idle_after) idle(2);
  endtask

  initial begin
    frames[0] = '{3, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1};
    frames[1] = '{3, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1};
    frames[2] = '{3, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1};
    frames[3] = '{0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1};
    frames[4] = '{8, 32'h00000100, 1'b0, 1'b1, 1'b1, 1'b1};
    frames[5] = '{2, 32'h00000200, 1'b0, 1'b0, 1'b0, 1'b0};
    frames[6] = '{2, 32'h00000300, 1'b0, 1'b0, 1'b0, 1'b1};

    #3;
    check_output("reset_i_rdy", {31'b0, i_rdy}, 32'd1);
    check_output("reset_o_val", {31'b0, o_val}, 32'd0);
    check_output("reset_stat_val", {31'b0, stat_val}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) apply_stimulus(frames[k]);

    // Reset after two of five dwords: only the first has been emitted.
    out_q.push_back('{32'h000000A0, 1'b0, 1'b0});
    send_word(32'h000000A0, 1'b0, 1'b0);
    send_word(32'h000000A1, 1'b0, 1'b0);
    @(negedge clk);
    i_val = 1'b1;
    i_dat = 32'h000000A2;
    i_eop = 1'b0;
    reset = 1'b1;
    #2;
    check_output("midrst_i_rdy", {31'b0, i_rdy}, 32'd1);
    check_output("midrst_o_val", {31'b0, o_val}, 32'd0);
    check_output("midrst_o_dat", o_dat, 32'd0);
    check_output("midrst_stat_val", {31'b0, stat_val}, 32'd0);
    check_output("midrst_stat_err", {31'b0, stat_err}, 32'd0);
    @(negedge clk);
    i_val = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    apply_stimulus('{3, 32'h00000400, 1'b0, 1'b0, 1'b0, 1'b1});

    idle(4);
    check_output("out_q_drained", out_q.size(), 32'd0);
    check_output("stat_q_drained", stat_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
